lsu_ctrl: RTL

//  Multi-cycle load/store unit between EXU and WBU. On a valid EXU op it issues one

---
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - multi-cycle load/store unit between EXU and WBU
module lsu_ctrl #(
    parameter int DW    = 64,
    parameter int FUNCW = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_exu_valid,
    output logic              o_lsu_ready,
    input  logic              i_ld_en,
    input  logic              i_st_en,
    input  logic [FUNCW-1:0]  i_lsfunc,
    input  logic [DW-1:0]     i_addr,
    input  logic [DW-1:0]     i_wdata,
    output logic [DW-1:0]     o_lsu_res,
    output logic              o_lsu_valid,
    output logic              o_lsu_misalign,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [DW-1:0]     o_mem_addr,
    output logic [DW-1:0]     o_mem_wdata,
    output logic [DW/8-1:0]   o_mem_wmask,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [DW-1:0]     i_mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               ld_q, st_q, mis_q;
    logic [FUNCW-1:0]   func_q;
    logic [DW-1:0]      addr_q, wdata_q, res_q;
    logic               accept, is_mem_in, misalign_in, mem_done;
    logic [DW-1:0]      shifted, ld_ext;
    logic [DW/8-1:0]    size_mask;

    assign accept    = i_exu_valid && (state_q == S_IDLE);
    assign is_mem_in = i_ld_en | i_st_en;
    assign mem_done  = ((state_q == S_REQ) && i_mem_ready && i_mem_rvalid) ||
                       ((state_q == S_RESP) && i_mem_rvalid);

    // Access size comes from lsfunc[1:0] for both signed and unsigned loads
    always_comb begin
        misalign_in = 1'b0;
        case (i_lsfunc[1:0])
            2'b00:   misalign_in = 1'b0;
            2'b01:   misalign_in = i_addr[0];
            2'b10:   misalign_in = |i_addr[1:0];
            default: misalign_in = |i_addr[2:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        o_lsu_ready = 1'b0;
        o_lsu_valid = 1'b0;
        o_mem_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_lsu_ready = 1'b1;
                if (accept)
                    state_d = (is_mem_in && !misalign_in) ? S_REQ : S_DONE;
            end
            S_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_ready)
                    state_d = i_mem_rvalid ? S_DONE : S_RESP;
            end
            S_RESP: begin
                if (i_mem_rvalid)
                    state_d = S_DONE;
            end
            default: begin
                o_lsu_valid = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        shifted = i_mem_rdata >> {addr_q[2:0], 3'b000};
        case (func_q)
            3'b000:  ld_ext = {{(DW-8){shifted[7]}},   shifted[7:0]};
            3'b001:  ld_ext = {{(DW-16){shifted[15]}}, shifted[15:0]};
            3'b010:  ld_ext = {{(DW-32){shifted[31]}}, shifted[31:0]};
            3'b100:  ld_ext = {{(DW-8){1'b0}},         shifted[7:0]};
            3'b101:  ld_ext = {{(DW-16){1'b0}},        shifted[15:0]};
            3'b110:  ld_ext = {{(DW-32){1'b0}},        shifted[31:0]};
            default: ld_ext = shifted;
        endcase
    end

    always_comb begin
        size_mask = '0;
        case (func_q[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Bus fields are only driven while a request is outstanding
    assign o_mem_we    = o_mem_req && st_q && !ld_q;
    assign o_mem_addr  = o_mem_req ? {addr_q[DW-1:3], 3'b000} : '0;
    assign o_mem_wdata = o_mem_req ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
    assign o_mem_wmask = o_mem_req ? (size_mask << addr_q[2:0]) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            func_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            res_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            if (accept) begin
                ld_q    <= i_ld_en;
                st_q    <= i_st_en;
                func_q  <= i_lsfunc;
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                if (!is_mem_in || misalign_in) begin
                    res_q <= '0;
                    mis_q <= is_mem_in;
                end
            end
            if (mem_done) begin
                res_q <= ld_q ? ld_ext : '0;
                mis_q <= 1'b0;
            end
        end
    end

    assign o_lsu_res      = res_q;
    assign o_lsu_misalign = mis_q;

endmodule
